// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO and its controller.
package fifo_pkg;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int DATA_WIDTH_DEF = 8;

  function automatic int fifo_depth(input int addr_width);
    return 2 ** addr_width;
  endfunction

  function automatic int fifo_cnt_w(input int addr_width);
    return addr_width + 1;
  endfunction
endpackage

// File: rtl/fifo_if.sv
// Strobe/backpressure bus between a FIFO and its producer/consumer.
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  localparam int CNT_W = fifo_cnt_w(ADDR_WIDTH);

  logic                  wr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  rd;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  empty;
  logic                  full;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr, w_data, rd,
    input  r_data, empty, full, count, overflow, underflow
  );

  modport slave (
    input  wr, w_data, rd,
    output r_data, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller; all outputs except wr_ok are registered.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  localparam int CNT_W     = fifo_cnt_w(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  wr_ok,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);
  logic [ADDR_WIDTH-1:0] w_ptr, r_ptr, w_nxt, r_nxt;
  logic                  rd_ok;

  // A write into a full FIFO is still accepted when a pop frees the head slot.
  assign wr_ok  = wr & (~full | rd);
  assign rd_ok  = rd & ~empty;
  assign w_nxt  = w_ptr + ADDR_WIDTH'(1);
  assign r_nxt  = r_ptr + ADDR_WIDTH'(1);
  assign w_addr = w_ptr;
  assign r_addr = r_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr & full & ~rd;
      underflow <= rd & empty;
      unique case ({wr_ok, rd_ok})
        2'b10: begin
          w_ptr <= w_nxt;
          empty <= 1'b0;
          full  <= (w_nxt == r_ptr);
          count <= count + CNT_W'(1);
        end
        2'b01: begin
          r_ptr <= r_nxt;
          full  <= 1'b0;
          empty <= (r_nxt == w_ptr);
          count <= count - CNT_W'(1);
        end
        2'b11: begin
          w_ptr <= w_nxt;
          r_ptr <= r_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO: register-array storage with first-word-fall-through read.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic  clk,
  input logic  reset,
  fifo_if.slave bus
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_addr, r_addr;
  logic                  wr_ok;

  fifo_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .wr        (bus.wr),
    .rd        (bus.rd),
    .w_addr    (w_addr),
    .r_addr    (r_addr),
    .wr_ok     (wr_ok),
    .full      (bus.full),
    .empty     (bus.empty),
    .count     (bus.count),
    .overflow  (bus.overflow),
    .underflow (bus.underflow)
  );

  // Storage is deliberately left unreset; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[w_addr] <= bus.w_data;
  end

  assign bus.r_data = mem[r_addr];
endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync with hand-computed expectations.
module tb_fifo_sync;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fifo_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

  fifo_sync #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    bus.wr     = w;
    bus.w_data = d;
    bus.rd     = r;
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  initial begin
    bus.wr = 1'b0; bus.rd = 1'b0; bus.w_data = '0;
    #12;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_unf", bus.underflow, 0);
    @(negedge clk); reset = 1'b0;

    // Fill to full
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'h10 + 8'(i), 1'b0);
      chk("fill_count", bus.count, i + 1);
      chk("fill_empty", bus.empty, 0);
      chk("fill_full", bus.full, (i == 7));
      chk("fill_head", bus.r_data, 8'h10);
    end
    cyc(1'b1, 8'hFF, 1'b0);
    chk("ovf_pulse", bus.overflow, 1);
    chk("ovf_count", bus.count, 8);
    chk("ovf_full", bus.full, 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", bus.overflow, 0);

    // Drain; 0xFF must never appear
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", bus.r_data, 8'h10 + 8'(i));
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_count", bus.count, 7 - i);
      chk("drain_empty", bus.empty, (i == 7));
      chk("drain_full", bus.full, 0);
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk("unf_pulse", bus.underflow, 1);
    chk("unf_count", bus.count, 0);
    chk("unf_empty", bus.empty, 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("unf_clear", bus.underflow, 0);

    // Full with simultaneous write and read
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
    chk("refill_full", bus.full, 1);
    chk("refill_head", bus.r_data, 8'h10);
    cyc(1'b1, 8'hAA, 1'b1);
    chk("fwr_full", bus.full, 1);
    chk("fwr_count", bus.count, 8);
    chk("fwr_ovf", bus.overflow, 0);
    for (int i = 0; i < 8; i++) begin
      chk("fwr_drain", bus.r_data, (i == 7) ? 8'hAA : 8'h11 + 8'(i));
      cyc(1'b0, 8'h00, 1'b1);
    end
    chk("fwr_empty", bus.empty, 1);

    // Empty with simultaneous write and read
    cyc(1'b1, 8'h55, 1'b1);
    chk("ewr_empty", bus.empty, 0);
    chk("ewr_count", bus.count, 1);
    chk("ewr_unf", bus.underflow, 1);
    chk("ewr_data", bus.r_data, 8'h55);
    cyc(1'b0, 8'h00, 1'b1);
    chk("ewr_unf_clr", bus.underflow, 0);
    chk("ewr_drained", bus.empty, 1);

    // Interleaved pairs crossing the pointer wrap
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'h80 + 8'(i), 1'b0);
      chk("wrap_count1", bus.count, 1);
      chk("wrap_data", bus.r_data, 8'h80 + 8'(i));
      chk("wrap_full", bus.full, 0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("wrap_count0", bus.count, 0);
      chk("wrap_empty", bus.empty, 1);
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0);
    chk("pre_rst_count", bus.count, 5);
    #2 reset = 1'b1;
    #1;
    chk("arst_empty", bus.empty, 1);
    chk("arst_full", bus.full, 0);
    chk("arst_count", bus.count, 0);
    #2 reset = 1'b0;
    cyc(1'b1, 8'h3C, 1'b0);
    chk("post_rst_data", bus.r_data, 8'h3C);
    chk("post_rst_count", bus.count, 1);
    cyc(1'b1, 8'h3D, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_next", bus.r_data, 8'h3D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_sync.md
# fifo_sync

Synchronous single-clock FIFO built from a write-enabled register array with a combinational read port. It pairs a pointer/flag controller with that storage so producers and consumers exchange words through a `wr`/`rd` strobe interface with `full`/`empty` backpressure. It is the standard buffering element between datapath stages such as UART receive and transmit paths.

## Interface
- `ADDR_WIDTH`, 3: pointer width; depth = 2**ADDR_WIDTH.
- `DATA_WIDTH`, 8: word width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr`  in  1  write strobe; samples `w_data` at the rising edge.
- `w_data`  in  DATA_WIDTH  write word.
- `rd`  in  1  read/pop strobe; discards the head word at the rising edge.
- `r_data`  out  DATA_WIDTH  head word, first-word-fall-through, combinational from storage.
- `empty`  out  1  no valid words.
- `full`  out  1  2**ADDR_WIDTH valid words.
- `count`  out  ADDR_WIDTH+1  occupancy, 0..2**ADDR_WIDTH.
- `overflow`  out  1  one-cycle pulse: write dropped because the FIFO was full.
- `underflow`  out  1  one-cycle pulse: read ignored because the FIFO was empty.

## Operation
- State: `w_ptr`, `r_ptr` (ADDR_WIDTH bits each), registered `full`, `empty`, `count`, `overflow`, `underflow`.
- Reset (asynchronous): pointers = 0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `underflow`=0. Storage contents are not reset.
- Write accepted (`wr_ok`): `wr & (~full | rd)`. Storage[`w_ptr`] <= `w_data`, then `w_ptr`+1.
- Read accepted (`rd_ok`): `rd & ~empty`. `r_ptr`+1.
- Simultaneous `wr` and `rd`:
  - Not empty, not full: both accepted. `count` and flags unchanged.
  - Full: both accepted. The write lands in the slot freed by the read. `full` stays 1.
  - Empty: write only. `empty` goes to 0, `underflow` pulses.
- Write only: `empty`<=0, `count`+1. `full`<=1 when `w_ptr`+1 == `r_ptr`.
- Read only: `full`<=0, `count`-1. `empty`<=1 when `r_ptr`+1 == `w_ptr`.
- Pointers wrap modulo 2**ADDR_WIDTH with natural overflow; no explicit compare-to-depth.
- `overflow` <= `wr & full & ~rd`. `underflow` <= `rd & empty`. Neither changes any other state.
- `r_data` = storage[`r_ptr`]. It is valid only while `empty`=0 and is don't-care while empty.

## Timing
- Write-to-read latency: a word written at edge N appears on `r_data`, with `empty`=0, after edge N, i.e. it is readable in cycle N+1.
- Pop latency: after a read at edge N, `r_data` shows the next word in cycle N+1.
- `full`, `empty`, `count` update on the same edge as the pointer move. There is no combinational path from `wr`/`rd` to the flags.
- `overflow` and `underflow` are asserted for exactly the cycle after the offending edge.
- Reset asserted mid-stream: all outputs take their reset values immediately, without waiting for `clk`. The first write after reset deassertion goes to slot 0.

## Structure
- Shared package `fifo_pkg`: `localparam` helpers for depth (`2**ADDR_WIDTH`) and count width (`ADDR_WIDTH+1`).
- Sub-module `fifo_ctrl`: pointers, flags, `count`, and error pulses.
  - Outputs `w_addr`, `r_addr`, and `wr_ok`.
  - Has no data path.
- Top `fifo_sync`:
  - Storage array with a synchronous write gated by `wr_ok` and a combinational read at `r_addr`.
  - Instantiates `fifo_ctrl`.

## Test plan
- Reset, then 8 writes of 0x10..0x17 (ADDR_WIDTH=3) -> `full`=1 and `count`=8 after the 8th edge. A 9th write of 0xFF -> `overflow` pulses one cycle, `count` stays 8, data is not stored.
- Drain 8 reads -> `r_data` sequence 0x10..0x17, `empty`=1 after the 8th edge. A further read -> `underflow` pulses, pointers unchanged.
- Full FIFO, `wr` and `rd` together with `w_data`=0xAA -> 0x10 popped, `full` stays 1, `count`=8. After draining, 0xAA is the last word out.
- Empty FIFO, `wr` and `rd` together with 0x55 -> `empty`=0, `count`=1, `underflow` pulses, next-cycle `r_data`=0x55.
- Wrap-around: 20 interleaved write/read pairs with incrementing data -> output order is preserved across the pointer wrap, `count` never exceeds 8, flags are correct at each edge.
- Assert `reset` between clock edges with `count`=5 -> `empty`=1, `full`=0, `count`=0 immediately. A write of 0x3C after release -> `r_data`=0x3C next cycle.
